// File: rtl/pipe_mux_pkg.sv
// Shared constants and select-width helper for the pipe_mux slice.
// Holds defaults only; no logic, latency or flow control here.
// Imported by pipe_mux and rr_arb so both size the select identically.
package pipe_mux_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 5;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin grant: lowest-index requester strictly after last, wrapping.
// Latency 0 (purely combinational); the caller decides when last advances.
// No backpressure of its own; a grant is only a candidate until transferred.
module rr_arb
    import pipe_mux_pkg::*;
#(
    parameter  int N     = DEF_N,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] grant,
    output logic             grant_vld
);

    int idx;

    // Scan farthest-first so the nearest requester after last overwrites.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                grant     = idx[SEL_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_mux.sv
// N-to-1 channel mux into a single-entry output register; round-robin mode under PIPE_MUX_RR_EN.
// Latency 1 cycle from accepted input to O/O_V; sustains one word per cycle.
// Backpressure: IN_R deasserts while O_V && !O_R; held word stays stable until taken.
module pipe_mux
    import pipe_mux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N     = DEF_N,
    localparam int SEL_W = sel_width(N)
) (
`ifdef PIPE_MUX_RR_EN
    input  logic               RR,
`endif
    input  logic               CLK,
    input  logic               RST,
    input  logic [N*WIDTH-1:0] IN,
    input  logic [N-1:0]       IN_V,
    output logic [N-1:0]       IN_R,
    input  logic [SEL_W-1:0]   S,
    output logic [WIDTH-1:0]   O,
    output logic               O_V,
    input  logic               O_R,
    output logic               ERR
);

    logic [SEL_W-1:0] sel;
    logic             sel_ok;
    logic             err_set;
    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] in_word;

`ifdef PIPE_MUX_RR_EN
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;

    rr_arb #(.N(N)) u_rr_arb (
        .req       (IN_V),
        .last      (last),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    // Illegal-select tracking only applies when S is actually in use.
    always_comb begin
        sel     = S;
        sel_ok  = int'(S) < N;
        err_set = 1'b0;
        if (RR) begin
            sel    = grant;
            sel_ok = grant_vld;
        end else begin
            err_set = !sel_ok && (|IN_V);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last <= SEL_W'(N - 1);
        end else if (xfer && RR) begin
            last <= sel;
        end
    end
`else
    always_comb begin
        sel     = S;
        sel_ok  = int'(S) < N;
        err_set = !sel_ok && (|IN_V);
    end
`endif

    assign accept = !O_V || O_R;

    always_comb begin
        IN_R    = '0;
        in_word = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) begin
                IN_R[i] = accept && sel_ok && !RST;
                in_word = IN[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(IN_R & IN_V);

    always_ff @(posedge CLK) begin
        if (RST) begin
            O   <= '0;
            O_V <= 1'b0;
            ERR <= 1'b0;
        end else begin
            if (xfer) begin
                O   <= in_word;
                O_V <= 1'b1;
            end else if (O_R) begin
                O_V <= 1'b0;
            end
            if (err_set) begin
                ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mux.sv
// Directed bench for pipe_mux: select, backpressure, illegal select, reset, round-robin.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_pipe_mux;

    localparam int W  = 16;
    localparam int NC = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC*W-1:0] in_bus;
    logic [NC-1:0]   in_v;
    logic [NC-1:0]   in_r;
    logic [2:0]      s;
    logic [W-1:0]    o;
    logic            o_v;
    logic            o_r;
    logic            err;
`ifdef PIPE_MUX_RR_EN
    logic            rr;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pipe_mux #(.WIDTH(W), .N(NC)) dut (
`ifdef PIPE_MUX_RR_EN
        .RR   (rr),
`endif
        .CLK  (clk),
        .RST  (rst),
        .IN   (in_bus),
        .IN_V (in_v),
        .IN_R (in_r),
        .S    (s),
        .O    (o),
        .O_V  (o_v),
        .O_R  (o_r),
        .ERR  (err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_v = 5'b11111; s = 3'd0; o_r = 1'b1;
        #1;
        vecs++; if (in_r !== 5'b00000) begin errs++; $display("FAIL reset_in_r got %b want 00000", in_r); end
        tick();
        vecs++; if (o !== 16'd0) begin errs++; $display("FAIL reset_o got %0d want 0", o); end
        vecs++; if (o_v !== 1'b0) begin errs++; $display("FAIL reset_o_v got %b want 0", o_v); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0; in_v = 5'b00000;
        tick();
    endtask

    task automatic test_select();
        in_v = 5'b11111; s = 3'd3; o_r = 1'b1;
        #1;
        vecs++; if (in_r !== 5'b01000) begin errs++; $display("FAIL sel3_in_r got %b want 01000", in_r); end
        tick();
        vecs++; if (o !== 16'd20 || o_v !== 1'b1) begin errs++; $display("FAIL sel3_out got %0d/%b want 20/1", o, o_v); end
        s = 3'd0;
        tick();
        vecs++; if (o !== 16'd5 || o_v !== 1'b1) begin errs++; $display("FAIL b2b_sel0 got %0d/%b want 5/1", o, o_v); end
        s = 3'd4;
        tick();
        vecs++; if (o !== 16'd25 || o_v !== 1'b1) begin errs++; $display("FAIL b2b_sel4 got %0d/%b want 25/1", o, o_v); end
        // ch2 not valid while selected: neighbours must not leak through
        s = 3'd2; in_v = 5'b11011;
        #1;
        vecs++; if (in_r !== 5'b00100) begin errs++; $display("FAIL unsel_in_r got %b want 00100", in_r); end
        tick();
        vecs++; if (o !== 16'd25 || o_v !== 1'b0) begin errs++; $display("FAIL unsel_out got %0d/%b want 25/0", o, o_v); end
    endtask

    task automatic test_backpressure();
        in_v = 5'b11111; s = 3'd1; o_r = 1'b0;
        tick();
        vecs++; if (o !== 16'd10 || o_v !== 1'b1) begin errs++; $display("FAIL bp_load got %0d/%b want 10/1", o, o_v); end
        vecs++; if (in_r !== 5'b00000) begin errs++; $display("FAIL bp_stall1_in_r got %b want 00000", in_r); end
        tick();
        vecs++; if (o !== 16'd10 || o_v !== 1'b1) begin errs++; $display("FAIL bp_hold1 got %0d/%b want 10/1", o, o_v); end
        s = 3'd4;
        #1;
        vecs++; if (in_r !== 5'b00000) begin errs++; $display("FAIL bp_stall2_in_r got %b want 00000", in_r); end
        tick();
        vecs++; if (o !== 16'd10 || o_v !== 1'b1) begin errs++; $display("FAIL bp_hold2 got %0d/%b want 10/1", o, o_v); end
        o_r = 1'b1;
        #1;
        vecs++; if (in_r !== 5'b10000) begin errs++; $display("FAIL bp_release_in_r got %b want 10000", in_r); end
        tick();
        vecs++; if (o !== 16'd25 || o_v !== 1'b1) begin errs++; $display("FAIL bp_release got %0d/%b want 25/1", o, o_v); end
        in_v = 5'b00000;
        tick();
        vecs++; if (o !== 16'd25 || o_v !== 1'b0) begin errs++; $display("FAIL bp_drain got %0d/%b want 25/0", o, o_v); end
    endtask

    task automatic test_illegal();
        s = 3'd5; in_v = 5'b00000; o_r = 1'b1;
        tick();
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL ill_idle_err got %b want 0", err); end
        s = 3'd6; in_v = 5'b11111;
        #1;
        vecs++; if (in_r !== 5'b00000) begin errs++; $display("FAIL ill_in_r got %b want 00000", in_r); end
        tick();
        vecs++; if (err !== 1'b1 || o_v !== 1'b0) begin errs++; $display("FAIL ill_err got err=%b o_v=%b want 1/0", err, o_v); end
        s = 3'd0;
        tick();
        vecs++; if (err !== 1'b1 || o !== 16'd5 || o_v !== 1'b1) begin errs++; $display("FAIL ill_sticky got err=%b o=%0d want 1/5", err, o); end
    endtask

    task automatic test_reset_mid();
        s = 3'd2; in_v = 5'b11111; o_r = 1'b1;
        tick();
        o_r = 1'b0;
        tick();
        vecs++; if (o !== 16'd15 || o_v !== 1'b1) begin errs++; $display("FAIL rmid_hold got %0d/%b want 15/1", o, o_v); end
        rst = 1'b1; o_r = 1'b1;
        #1;
        vecs++; if (in_r !== 5'b00000) begin errs++; $display("FAIL rmid_in_r got %b want 00000", in_r); end
        tick();
        vecs++; if (o !== 16'd0 || o_v !== 1'b0 || err !== 1'b0) begin errs++; $display("FAIL rmid_clear got o=%0d o_v=%b err=%b want 0/0/0", o, o_v, err); end
        rst = 1'b0; s = 3'd0;
        #1;
        vecs++; if (in_r !== 5'b00001) begin errs++; $display("FAIL rmid_first_in_r got %b want 00001", in_r); end
        tick();
        vecs++; if (o !== 16'd5 || o_v !== 1'b1) begin errs++; $display("FAIL rmid_first got %0d/%b want 5/1", o, o_v); end
        in_v = 5'b00000;
        tick();
    endtask

`ifdef PIPE_MUX_RR_EN
    task automatic test_round_robin();
        logic [W-1:0] exp_o [4];
        exp_o[0] = 16'd5; exp_o[1] = 16'd15; exp_o[2] = 16'd25; exp_o[3] = 16'd5;
        rst = 1'b1; tick(); rst = 1'b0;
        rr = 1'b1; s = 3'd7; in_v = 5'b10101; o_r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vecs++; if (o !== exp_o[k] || o_v !== 1'b1) begin errs++; $display("FAIL rr_seq%0d got %0d/%b want %0d/1", k, o, o_v, exp_o[k]); end
        end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL rr_err got %b want 0", err); end
        // stall after ch0: pointer must not advance
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        vecs++; if (o !== 16'd5) begin errs++; $display("FAIL rr_stall_first got %0d want 5", o); end
        o_r = 1'b0;
        tick(); tick();
        vecs++; if (o !== 16'd5 || in_r !== 5'b00000) begin errs++; $display("FAIL rr_stall_hold got o=%0d in_r=%b want 5/00000", o, in_r); end
        o_r = 1'b1;
        tick();
        vecs++; if (o !== 16'd15) begin errs++; $display("FAIL rr_stall_resume got %0d want 15", o); end
        rr = 1'b0; in_v = 5'b00000;
        tick();
    endtask
`endif

    initial begin
        in_bus = {16'd25, 16'd20, 16'd15, 16'd10, 16'd5};
        rst = 1'b1; in_v = '0; s = '0; o_r = 1'b0;
`ifdef PIPE_MUX_RR_EN
        rr = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_select();
        test_backpressure();
        test_illegal();
        test_reset_mid();
`ifdef PIPE_MUX_RR_EN
        test_round_robin();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
